// File: rtl/iob_eth_rx_reader.sv
// Bus master that drains received frames from the Ethernet core register
// interface (status poll, size read, buffer words, RCVACK) into a word stream.
module iob_eth_rx_reader #(
  parameter int unsigned ETH_ADDR_W = 12,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  eth_valid,
  output logic [ETH_ADDR_W-1:0] eth_addr,
  output logic [3:0]            eth_wstrb,
  output logic [31:0]           eth_wdata,
  input  logic [31:0]           eth_rdata,
  input  logic                  eth_ready,
  output logic [31:0]           m_data,
  output logic [3:0]            m_keep,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [10:0]           frame_nbytes,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  busy
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  localparam logic [ETH_ADDR_W-1:0] ETH_STATUS   = ETH_ADDR_W'(12'h004);
  localparam logic [ETH_ADDR_W-1:0] ETH_RCV_SIZE = ETH_ADDR_W'(12'h00C);
  localparam logic [ETH_ADDR_W-1:0] ETH_RCVACK   = ETH_ADDR_W'(12'h014);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_WAIT,
    S_POLL,
    S_SIZE,
    S_RD,
    S_OUT,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [11:0]           idx_q, idx_d;
  logic [11:0]           nwords_q, nwords_d;
  logic                  eth_valid_q, eth_valid_d;
  logic [ETH_ADDR_W-1:0] eth_addr_q, eth_addr_d;
  logic [3:0]            eth_wstrb_q, eth_wstrb_d;
  logic [31:0]           eth_wdata_q, eth_wdata_d;
  logic [31:0]           m_data_q, m_data_d;
  logic [3:0]            m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic                  m_valid_q, m_valid_d;
  logic [10:0]           nbytes_q, nbytes_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  rd_last_c;

  // Buffer word i lives at {1, zeros, i[8:0]}
  function automatic logic [ETH_ADDR_W-1:0] buf_addr(input logic [11:0] i);
    logic [ETH_ADDR_W-1:0] a;
    a                 = '0;
    a[ETH_ADDR_W-1]   = 1'b1;
    a[8:0]            = i[8:0];
    return a;
  endfunction

  function automatic logic [3:0] tail_keep(input logic [1:0] nb);
    logic [3:0] k;
    case (nb)
      2'd1:    k = 4'b0001;
      2'd2:    k = 4'b0011;
      2'd3:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      idx_q       <= '0;
      nwords_q    <= '0;
      eth_valid_q <= 1'b0;
      eth_addr_q  <= '0;
      eth_wstrb_q <= '0;
      eth_wdata_q <= '0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      nwords_q    <= nwords_d;
      eth_valid_q <= eth_valid_d;
      eth_addr_q  <= eth_addr_d;
      eth_wstrb_q <= eth_wstrb_d;
      eth_wdata_q <= eth_wdata_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; every access is launched on the transition into its state
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    idx_d       = idx_q;
    nwords_d    = nwords_q;
    eth_valid_d = 1'b0;
    eth_addr_d  = eth_addr_q;
    eth_wstrb_d = eth_wstrb_q;
    eth_wdata_d = eth_wdata_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    rd_last_c   = (idx_q == (nwords_q - 12'd1));

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_POLL_WAIT;
          gap_d   = GAP_LOAD;
        end
      end

      S_POLL_WAIT: begin
        if (gap_q == '0) begin
          state_d     = S_POLL;
          eth_valid_d = 1'b1;
          eth_addr_d  = ETH_STATUS;
          eth_wstrb_d = 4'h0;
          eth_wdata_d = 32'd0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_POLL: begin
        if (eth_ready) begin
          if (eth_rdata[1]) begin
            state_d     = S_SIZE;
            eth_valid_d = 1'b1;
            eth_addr_d  = ETH_RCV_SIZE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_SIZE: begin
        if (eth_ready) begin
          nbytes_d = eth_rdata[10:0];
          nwords_d = (12'(eth_rdata[10:0]) + 12'd3) >> 2;
          idx_d    = '0;
          eth_valid_d = 1'b1;
          if (eth_rdata[10:0] == 11'd0) begin
            state_d     = S_ACK;
            eth_addr_d  = ETH_RCVACK;
            eth_wstrb_d = 4'hF;
            eth_wdata_d = 32'd1;
          end else begin
            state_d    = S_RD;
            eth_addr_d = buf_addr(12'd0);
          end
        end
      end

      S_RD: begin
        if (eth_ready) begin
          state_d   = S_OUT;
          m_data_d  = eth_rdata;
          m_valid_d = 1'b1;
          m_last_d  = rd_last_c;
          m_keep_d  = rd_last_c ? tail_keep(nbytes_q[1:0]) : 4'hF;
        end
      end

      S_OUT: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          idx_d       = idx_q + 12'd1;
          eth_valid_d = 1'b1;
          if (m_last_q) begin
            state_d     = S_ACK;
            eth_addr_d  = ETH_RCVACK;
            eth_wstrb_d = 4'hF;
            eth_wdata_d = 32'd1;
          end else begin
            state_d    = S_RD;
            eth_addr_d = buf_addr(idx_q + 12'd1);
          end
        end
      end

      S_ACK: begin
        if (eth_ready) begin
          state_d     = S_IDLE;
          cnt_d       = cnt_q + CNT_W'(1);
          eth_wstrb_d = 4'h0;
          eth_wdata_d = 32'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign eth_valid    = eth_valid_q;
  assign eth_addr     = eth_addr_q;
  assign eth_wstrb    = eth_wstrb_q;
  assign eth_wdata    = eth_wdata_q;
  assign m_data       = m_data_q;
  assign m_keep       = m_keep_q;
  assign m_last       = m_last_q;
  assign m_valid      = m_valid_q;
  assign frame_nbytes = nbytes_q;
  assign frame_cnt    = cnt_q;
  assign busy         = busy_q;

endmodule

// File: doc/iob_eth_rx_reader.md
# iob_eth_rx_reader

Single-clock bus master that drains received Ethernet frames from the Ethernet core's CPU-side register interface and presents them as a 32-bit valid/ready word stream. It sits directly on the core's native interface (`valid`/`ready`/`wstrb`/`addr`/`data_in`/`data_out`), in place of software polling. For each frame it polls status, reads the frame size, reads the RX buffer word by word and writes the receive acknowledge.

## Interface
Parameters:
- `ETH_ADDR_W`, 12: width of the core address bus; bit `ETH_ADDR_W-1` selects the data buffer.
- `POLL_GAP`, 16: idle cycles between consecutive status polls (must be ≥ 1).
- `CNT_W`, 16: width of the frame counter.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: enables frame draining; sampled only in IDLE.
- `eth_valid` out 1: access request to the core; one-cycle pulse per access.
- `eth_addr` out `ETH_ADDR_W`: core address, held from `eth_valid` until `eth_ready`.
- `eth_wstrb` out 4: `4'hF` for the RCVACK write, `0` for reads.
- `eth_wdata` out 32: `32'd1` during the RCVACK write, else `0`.
- `eth_rdata` in 32: core read data, valid in the cycle `eth_ready`=1.
- `eth_ready` in 1: core access completion; arrives one cycle after `eth_valid`.
- `m_data` out 32: frame word; byte 0 sits in bits [7:0].
- `m_keep` out 4: valid-byte mask for the word.
- `m_last` out 1: marks the final word of the frame.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `frame_nbytes` out 11: byte count of the current or last frame.
- `frame_cnt` out `CNT_W`: number of frames completed; wraps modulo 2^`CNT_W`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Register addresses come from the core's swreg defines: `ETH_STATUS`, `ETH_RCV_SIZE`, `ETH_RCVACK`. Data word i is read at address `{1'b1, 0…, i[8:0]}`.
- Bus access rule:
  - Assert `eth_valid` for exactly one cycle.
  - Hold `eth_addr`, `eth_wstrb` and `eth_wdata` until `eth_ready`=1.
  - Capture `eth_rdata` in the `eth_ready` cycle.
  - Never issue a new access in the `eth_ready` cycle.
- FSM states:
  - **IDLE**: if `en`=1, go to POLL_WAIT. The gap counter loads `POLL_GAP-1`.
  - **POLL_WAIT**: count down; at 0 go to POLL.
  - **POLL**: read `ETH_STATUS`. If bit 1 (rx_data_rcvd)=1, go to SIZE. Otherwise go to IDLE, which re-evaluates `en`.
  - **SIZE**: read `ETH_RCV_SIZE` and latch `frame_nbytes`=`rdata[10:0]`. Compute `nwords`=(`nbytes`+3)>>2 in 12 bits. Clear word index `idx`. If `nbytes`=0, go to ACK; else go to RD.
  - **RD**: read data word `idx`. The captured data goes to the output register; then go to OUT.
  - **OUT**: hold `m_valid`=1 and stable `m_data`/`m_keep`/`m_last` until `m_ready`=1.
    - On the handshake, `idx` increments.
    - If `idx`=`nwords`-1, go to ACK; else go to RD.
  - **ACK**: write `32'd1` to `ETH_RCVACK`. On `eth_ready`, `frame_cnt` increments; go to IDLE.
- `m_keep` is `4'hF` for every word except the last. On the last word it is derived from `nbytes[1:0]`: 1→`0001`, 2→`0011`, 3→`0111`, 0→`1111`.
- `m_last`=1 only when `idx`=`nwords`-1.
- `en` deasserted mid-frame has no effect; the frame completes including ACK.
- `frame_nbytes` holds its value until the next SIZE capture.

## Timing
- Reset values: `eth_valid`=0, `eth_addr`=0, `eth_wstrb`=0, `eth_wdata`=0, `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0, `frame_nbytes`=0, `frame_cnt`=0, `busy`=0. State is IDLE.
- Reset asserted mid-frame: state returns to IDLE immediately. The frame is not acknowledged and is re-read after reset.
- Each bus access takes 2 cycles (valid, then ready).
- `m_valid` rises the cycle after the data read's `eth_ready`.
- Steady-state word throughput with `m_ready`=1: one word per 3 cycles (RD valid, RD ready, OUT handshake).
- First-word latency from the cycle POLL sees the status bit: 5 cycles.
- Poll period with no frame pending and `en`=1: `POLL_GAP` + 3 cycles.
- `m_ready` held low: the block stalls indefinitely in OUT and issues no bus traffic.
- `frame_cnt` wraps from all-ones to 0 with no flag.

## Test plan
- **Idle poll.** Hold `en`=1 with no frame. Require a status read every `POLL_GAP`+3 cycles, `m_valid` never asserted and `busy` pulsing.
- **64-byte frame.** Status=2, size=64, buffer words 0..15 = `0x03020100`+`0x04040404`·i.
  - Require 16 words in order with `m_keep`=F.
  - Require `m_last` only on word 15.
  - Require one RCVACK write of 1, and `frame_cnt` at 1.
- **Odd length.** Size=61 → 16 words; last `m_keep`=`0001`. Size=1 → 1 word, `m_keep`=`0001`, `m_last`=1.
- **Zero length.** Size=0 → no stream words, ACK issued, `frame_cnt` increments.
- **Backpressure.** Drive `m_ready` low for 10 cycles on word 3. Require `m_data` stable, no `eth_valid` pulses, and correct continuation afterwards.
- **Reset and enable.**
  - Assert `rst` on word 5; require all outputs back to reset values on the same cycle.
  - Drop `en` mid-frame; require the frame to complete with ACK and then no further polls.
